// File: rtl/bus_source_arbiter_if.sv
// Bus ownership signals between the requesting sources and the source arbiter.
// The arbiter side drives the mux select and grants; requesters drive Request/Done.
interface bus_source_arbiter_if;
    logic [15:0] Request;
    logic        Done;
    logic [3:0]  Select;
    logic [15:0] Grant;
    logic        BusValid;

    modport master (input Request, Done, output Select, Grant, BusValid);
    modport slave  (output Request, Done, input Select, Grant, BusValid);
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin owner selection for the 16-source data bus mux, with bounded
// tenure and a single dead cycle between owners. All outputs are registered.
module bus_source_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input logic                  Clock,
    input logic                  Reset,
    bus_source_arbiter_if.master bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWNED, RECOVER} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [3:0]  owner, owner_nxt;
    logic [3:0]  sel, sel_nxt;
    logic [15:0] gnt, gnt_nxt;
    logic        bv, bv_nxt;
    logic [7:0]  hold, hold_nxt;

    logic        found;
    logic [3:0]  win;
    logic        others;
    logic        tenure_end;

    // First requester at or after ptr, wrapping mod 16.
    always_comb begin
        logic [3:0] idx;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && bus.Request[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign others     = |(bus.Request & ~(16'd1 << owner));
    assign tenure_end = bus.Done || !bus.Request[owner] || ((hold >= HOLD_LIM) && others);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        bv_nxt    = bv;
        hold_nxt  = hold;
        unique case (state)
            IDLE, RECOVER: begin
                if (found) begin
                    owner_nxt = win;
                    sel_nxt   = win;
                    gnt_nxt   = 16'd1 << win;
                    bv_nxt    = 1'b1;
                    hold_nxt  = 8'd0;
                    state_nxt = OWNED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWNED: begin
                hold_nxt = (hold == 8'hFF) ? hold : hold + 8'd1;
                // Select stays on the old owner through the dead cycle.
                if (tenure_end) begin
                    gnt_nxt   = 16'd0;
                    bv_nxt    = 1'b0;
                    ptr_nxt   = owner + 4'd1;
                    state_nxt = RECOVER;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= 4'd0;
            owner <= 4'd0;
            sel   <= 4'd0;
            gnt   <= 16'd0;
            bv    <= 1'b0;
            hold  <= 8'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            bv    <= bv_nxt;
            hold  <= hold_nxt;
        end
    end

    assign bus.Select   = sel;
    assign bus.Grant    = gnt;
    assign bus.BusValid = bv;
endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed vector table for bus_source_arbiter (MAX_HOLD=4), plus a hand
// sequence for simultaneous Done and hold-limit preemption.
module tb_bus_source_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    bus_source_arbiter_if bus();

    bus_source_arbiter #(.MAX_HOLD(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        bv;
    } vec_t;

    vec_t vt[$];

    function automatic void add(logic r, logic [15:0] q, logic d,
                                logic [3:0] s, logic [15:0] g, logic b);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.sel = s; v.gnt = g; v.bv = b;
        vt.push_back(v);
    endfunction

    task automatic step(input logic r, input logic [15:0] q, input logic d);
        @(negedge clk);
        rst = r;
        bus.Request = q;
        bus.Done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        bus.Request = 16'h0;
        bus.Done = 1'b0;

        // reset, then first grant to source 0
        add(1, 16'hFFFF, 0, 4'h0, 16'h0000, 0);
        add(1, 16'hFFFF, 0, 4'h0, 16'h0000, 0);
        add(0, 16'hFFFF, 0, 4'h0, 16'h0001, 1);
        add(0, 16'h0000, 0, 4'h0, 16'h0000, 0);
        add(0, 16'h0000, 0, 4'h0, 16'h0000, 0);
        // single requester 5, Done in 3rd owned cycle, sole-requester regrant
        add(0, 16'h0020, 0, 4'h5, 16'h0020, 1);
        add(0, 16'h0020, 0, 4'h5, 16'h0020, 1);
        add(0, 16'h0020, 0, 4'h5, 16'h0020, 1);
        add(0, 16'h0020, 1, 4'h5, 16'h0000, 0);
        add(0, 16'h0020, 0, 4'h5, 16'h0020, 1);
        add(0, 16'h0000, 0, 4'h5, 16'h0000, 0);
        add(0, 16'h0000, 0, 4'h5, 16'h0000, 0);
        // round robin 0/15 with pointer wrap (ptr starts at 6)
        add(0, 16'h8001, 0, 4'hF, 16'h8000, 1);
        add(0, 16'h8001, 0, 4'hF, 16'h8000, 1);
        add(0, 16'h8001, 1, 4'hF, 16'h0000, 0);
        add(0, 16'h8001, 0, 4'h0, 16'h0001, 1);
        add(0, 16'h8001, 0, 4'h0, 16'h0001, 1);
        add(0, 16'h8001, 1, 4'h0, 16'h0000, 0);
        add(0, 16'h8001, 0, 4'hF, 16'h8000, 1);
        add(0, 16'h8001, 0, 4'hF, 16'h8000, 1);
        add(0, 16'h8001, 1, 4'hF, 16'h0000, 0);
        add(0, 16'h8001, 0, 4'h0, 16'h0001, 1);
        add(0, 16'h0000, 0, 4'h0, 16'h0000, 0);
        add(0, 16'h0000, 0, 4'h0, 16'h0000, 0);
        // preemption: 2 for 4 cycles, gap, 9 for 4 cycles, gap, 2
        for (int i = 0; i < 4; i++) add(0, 16'h0204, 0, 4'h2, 16'h0004, 1);
        add(0, 16'h0204, 0, 4'h2, 16'h0000, 0);
        for (int i = 0; i < 4; i++) add(0, 16'h0204, 0, 4'h9, 16'h0200, 1);
        add(0, 16'h0204, 0, 4'h9, 16'h0000, 0);
        add(0, 16'h0204, 0, 4'h2, 16'h0004, 1);
        // sole requester keeps the bus past the hold limit
        for (int i = 0; i < 6; i++) add(0, 16'h0004, 0, 4'h2, 16'h0004, 1);
        add(0, 16'h0204, 0, 4'h2, 16'h0000, 0);
        add(0, 16'h0000, 0, 4'h2, 16'h0000, 0);
        // request drop in 2nd cycle; Done while idle is ignored
        add(0, 16'h0010, 0, 4'h4, 16'h0010, 1);
        add(0, 16'h0010, 0, 4'h4, 16'h0010, 1);
        add(0, 16'h0000, 0, 4'h4, 16'h0000, 0);
        add(0, 16'h0000, 1, 4'h4, 16'h0000, 0);
        add(0, 16'h0000, 1, 4'h4, 16'h0000, 0);
        // reset mid-tenure of 7; next grant goes to 0
        add(0, 16'h0080, 0, 4'h7, 16'h0080, 1);
        add(0, 16'h0080, 0, 4'h7, 16'h0080, 1);
        add(1, 16'h0081, 0, 4'h0, 16'h0000, 0);
        add(0, 16'h0081, 0, 4'h0, 16'h0001, 1);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].req, vt[i].done);
            chk($sformatf("row%0d sel/gnt/bv", i),
                {11'd0, bus.Select, bus.Grant, bus.BusValid},
                {11'd0, vt[i].sel, vt[i].gnt, vt[i].bv});
        end

        // Done coinciding with the hold limit releases once
        step(1, 16'h0000, 0);
        step(0, 16'h0003, 0);
        seen = bus.BusValid;
        for (int i = 0; i < 5 && !seen; i++) begin
            step(0, 16'h0003, 0);
            seen = bus.BusValid;
        end
        chk("first grant seen", 32'(seen), 32'd1);
        n = 0;
        while (bus.BusValid && n < 20) begin
            n++;
            step(0, 16'h0003, (n == 4));
        end
        chk("tenure with done+limit", n, 4);
        chk("dead cycle select", 32'(bus.Select), 32'd0);
        step(0, 16'h0003, 0);
        chk("next owner", {bus.Select, bus.Grant, bus.BusValid}, {4'd1, 16'h0002, 1'b1});
        step(0, 16'h0003, 0);
        chk("no double release", {bus.Select, bus.Grant, bus.BusValid}, {4'd1, 16'h0002, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_source_arbiter.md
# bus_source_arbiter

Round-robin arbiter and sequencer for the shared 16-source, 8-bit data bus built from the 16-to-1 bus multiplexer. Up to 16 requesters contend for the bus. The block picks one owner, drives the multiplexer's 4-bit `Select` and a one-hot `Grant`, enforces a bounded tenure, and inserts one dead cycle between owners. It sits between the requesting units (registers, I/O, game-logic sources) and the mux select input.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum tenure in cycles while another requester is waiting. Legal range is 1..255.

Ports:
- `Clock` input, 1 bit: single clock. All state updates on the rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `Request` input, 16 bits: bit i set means source i wants the bus.
- `Done` input, 1 bit: the current owner ends its tenure. Ignored when there is no owner.
- `Select` output, 4 bits: index of the current or last owner. Wired to the mux select input.
- `Grant` output, 16 bits: one-hot for the current owner. All zero when there is no owner.
- `BusValid` output, 1 bit: the bus carries owner data this cycle.

## Operation

State and registers:
- States: IDLE, OWNED, RECOVER.
- Registers: `ptr` (4-bit search start), `owner` (4-bit), `hold` (8-bit saturating tenure counter).

Reset values:
- Synchronous, takes effect at the first edge with `Reset`=1.
- State goes to IDLE.
- `Select`=0, `Grant`=0, `BusValid`=0, `ptr`=0, `hold`=0.
- Reset overrides everything, including an active tenure.

Arbitration (used in IDLE and RECOVER):
- Search order is `ptr`, `ptr`+1, … , 15, 0, … , `ptr`-1, mod 16.
- The first index with `Request` set wins.
- On a winner:
  - `owner`=idx, `Select`=idx, `Grant`=1<<idx, `BusValid`=1.
  - `hold`=0, state goes to OWNED.
- With no request, state goes to (or stays in) IDLE and all outputs hold.

IDLE:
- Performs arbitration every cycle.

OWNED:
- `hold` increments each cycle and saturates at 255.
- Tenure ends at the first edge where any of these is true:
  - (a) `Done`=1.
  - (b) `Request[owner]`=0.
  - (c) `hold` ≥ `MAX_HOLD`-1 and some other `Request` bit is set.
- With no other requester, condition (c) never fires and the owner keeps the bus indefinitely.
- On tenure end:
  - `Grant`=0, `BusValid`=0.
  - `Select` keeps the old owner (no select glitch during the dead cycle).
  - `ptr`=`owner`+1 mod 16 (15 wraps to 0).
  - State goes to RECOVER.

RECOVER:
- Lasts exactly one cycle, with outputs as set at tenure end.
- At the next edge, performs arbitration using the updated `ptr`.
- The previous owner can win again only if it is the sole requester.

Invariants:
- `Grant` is zero or exactly one-hot.
- When `Grant`≠0, `Grant`==1<<`Select`.
- `BusValid`==(`Grant`≠0).

## Timing

- Grant latency: `Request` seen at edge N gives `Grant`/`Select`/`BusValid` valid after edge N (visible in cycle N+1). No combinational path from `Request` to outputs.
- Tenure length: measured from the first `BusValid` cycle.
  - Preemption by (c): exactly `MAX_HOLD` `BusValid` cycles.
  - `Done` asserted in the k-th owned cycle: k `BusValid` cycles.
- Owner-to-owner gap: exactly one cycle with `BusValid`=0 (RECOVER).
- Maximum wait for a continuously requesting source: 15 × (`MAX_HOLD`+1) cycles.
- Simultaneous `Done` and (c): single release, with the same behaviour as either alone.
- `Done` in IDLE or RECOVER: no effect.
- `Reset` asserted in any state: outputs reach reset values after that edge. `ptr` returns to 0.

## Test plan

1. **Reset:** hold `Reset` 2 cycles with `Request`=0xFFFF. Required: `Grant`=0, `BusValid`=0, `Select`=0 throughout. After release, first grant is to source 0 one cycle later.
2. **Single requester:** `Request`=0x0020 and `Done` pulsed in the 3rd owned cycle. Required:
   - `Select`=5, `Grant`=0x0020 for 3 cycles.
   - 1 dead cycle with `Select` still 5.
   - Re-grant to 5 because it is the sole requester.
3. **Round-robin:** `Request`=0x8001 constant, `Done` every 2nd owned cycle. Required: owners 0, 15, 0, 15, with a dead cycle between each. Covers the 15→0 pointer wrap.
4. **Preemption:** `MAX_HOLD`=4, `Request`=0x0204, no `Done`. Required:
   - Owner 2 for exactly 4 cycles, a dead cycle, then owner 9 for 4 cycles, then owner 2.
   - With `Request`=0x0004 alone, owner 2 keeps the bus beyond 4 cycles.
5. **Request drop:** the owner deasserts its `Request` in its 2nd cycle. Required: `BusValid`=0 at the next edge and RECOVER entered. `Done` pulses while IDLE cause no change.
6. **Reset mid-tenure:** source 7 owns the bus, then `Reset` is pulsed for 1 cycle with `Request`=0x0081. Required: outputs reach reset values after that edge. The next grant is to source 0 (`ptr` reset), not source 7.
